alu_cola_resultados: RTL and testbench

Result-capture stage directly downstream of the 32-bit ALU. Registers each ALU result (S) with its flags (Z, C, O) and operation code f into a small FIFO, and presents them to the consumer through a valid/ready handshake. Discards results of operation codes that do not select an ALU unit, counting them. Keeps sticky flag summaries for status reporting.

---
 rtl/alu_cola_resultados.sv | 175 +++++++++++++++++
 tb/tb_alu_cola_resultados.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_cola_resultados.sv
// rtl/alu_cola_resultados.sv - result-capture FIFO behind the 32-bit ALU with sticky flags and discard counter
//
// Purpose:
//   Captures each ALU result {S, Z, C, O, f} into a PROF-entry FIFO and hands it
//   to the consumer over a valid/ready handshake. Results whose operation code
//   does not select an ALU unit (f[3:2] = 00 or 11) are dropped and counted.
//   Sticky flag summaries accumulate over every stored result.
//
// Parameters:
//   PROF       FIFO depth in entries (power of two, >= 2)
//   ANCHO_CNT  width of the saturating discard counter
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid / in_ready             producer handshake (ALU side)
//   in_S, in_Z, in_C, in_O, in_f    ALU result, flags and operation code
//   out_valid / out_ready           consumer handshake
//   out_S, out_Z, out_C, out_O, out_f  head entry of the FIFO
//   ocupacion                       entries currently stored
//   pegajoso_Z, pegajoso_C, pegajoso_O  sticky flag summaries
//   limpiar                         synchronous clear of sticky flags and discard count
//   descartados                     saturating count of discarded results

module alu_cola_resultados #(
  parameter int PROF      = 4,
  parameter int ANCHO_CNT = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_S,
  input  logic                      in_Z,
  input  logic                      in_C,
  input  logic                      in_O,
  input  logic [3:0]                in_f,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_S,
  output logic                      out_Z,
  output logic                      out_C,
  output logic                      out_O,
  output logic [3:0]                out_f,
  output logic [$clog2(PROF):0]     ocupacion,
  output logic                      pegajoso_Z,
  output logic                      pegajoso_C,
  output logic                      pegajoso_O,
  input  logic                      limpiar,
  output logic [ANCHO_CNT-1:0]      descartados
);

  localparam int AW = $clog2(PROF);
  localparam int EW = 39;  // {S[31:0], Z, C, O, f[3:0]}
  localparam logic [AW:0] C_LLENO = (AW+1)'(PROF);
  localparam logic [AW:0] C_UNO   = (AW+1)'(1);
  localparam logic [1:0]  C_UNIDAD_ARIT   = 2'b01;
  localparam logic [1:0]  C_UNIDAD_LOGICA = 2'b10;

  // Storage is deliberately left out of reset; only pointers and counters are reset.
  logic [EW-1:0]        r_mem [PROF];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_ocup;
  logic                 r_out_valid;
  logic                 r_in_ready;
  logic                 r_peg_Z;
  logic                 r_peg_C;
  logic                 r_peg_O;
  logic [ANCHO_CNT-1:0] r_desc;

  logic                 w_accept;
  logic                 w_op_valida;
  logic                 w_op_arit;
  logic                 w_push;
  logic                 w_pop;
  logic [AW:0]          w_ocup_sig;
  logic [EW-1:0]        w_cabeza;
  logic                 w_peg_Z_base;
  logic                 w_peg_C_base;
  logic                 w_peg_O_base;
  logic [ANCHO_CNT-1:0] w_desc_base;

  // in_ready comes straight from a flop, so a full FIFO never accepts in the
  // cycle it pops: the consumer cannot make room combinationally.
  assign w_accept    = in_valid && r_in_ready;
  assign w_op_arit   = (in_f[3:2] == C_UNIDAD_ARIT);
  assign w_op_valida = w_op_arit || (in_f[3:2] == C_UNIDAD_LOGICA);
  assign w_push      = w_accept && w_op_valida;
  assign w_pop       = r_out_valid && out_ready;

  always_comb begin
    w_ocup_sig = r_ocup;
    if (w_push && !w_pop) begin
      w_ocup_sig = r_ocup + C_UNO;
    end else if (w_pop && !w_push) begin
      w_ocup_sig = r_ocup - C_UNO;
    end
  end

  // limpiar clears first; a same-cycle accept then updates on top of the cleared value.
  assign w_peg_Z_base = limpiar ? 1'b0 : r_peg_Z;
  assign w_peg_C_base = limpiar ? 1'b0 : r_peg_C;
  assign w_peg_O_base = limpiar ? 1'b0 : r_peg_O;
  assign w_desc_base  = limpiar ? '0 : r_desc;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_S, in_Z, in_C, in_O, in_f};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ocup      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_ocup      <= w_ocup_sig;
      r_out_valid <= (w_ocup_sig != '0);
      r_in_ready  <= (w_ocup_sig != C_LLENO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peg_Z <= 1'b0;
      r_peg_C <= 1'b0;
      r_peg_O <= 1'b0;
      r_desc  <= '0;
    end else begin
      r_peg_Z <= w_peg_Z_base;
      r_peg_C <= w_peg_C_base;
      r_peg_O <= w_peg_O_base;
      r_desc  <= w_desc_base;
      if (w_push) begin
        r_peg_Z <= w_peg_Z_base | in_Z;
        // Carry and overflow carry no meaning for logic-unit results.
        if (w_op_arit) begin
          r_peg_C <= w_peg_C_base | in_C;
          r_peg_O <= w_peg_O_base | in_O;
        end
      end else if (w_accept) begin
        if (w_desc_base != {ANCHO_CNT{1'b1}}) begin
          r_desc <= w_desc_base + ANCHO_CNT'(1);
        end
      end
    end
  end

  // Head slot is never the write target while out_valid=1 and not full,
  // so the outputs stay stable during a stall.
  assign w_cabeza = r_mem[r_rd_ptr];

  assign out_S       = w_cabeza[38:7];
  assign out_Z       = w_cabeza[6];
  assign out_C       = w_cabeza[5];
  assign out_O       = w_cabeza[4];
  assign out_f       = w_cabeza[3:0];
  assign out_valid   = r_out_valid;
  assign in_ready    = r_in_ready;
  assign ocupacion   = r_ocup;
  assign pegajoso_Z  = r_peg_Z;
  assign pegajoso_C  = r_peg_C;
  assign pegajoso_O  = r_peg_O;
  assign descartados = r_desc;

endmodule

// File: tb/tb_alu_cola_resultados.sv
// tb/tb_alu_cola_resultados.sv - directed self-checking bench for alu_cola_resultados

module tb_alu_cola_resultados;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_S;
  logic        in_Z;
  logic        in_C;
  logic        in_O;
  logic [3:0]  in_f;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_S;
  logic        out_Z;
  logic        out_C;
  logic        out_O;
  logic [3:0]  out_f;
  logic [2:0]  ocupacion;
  logic        pegajoso_Z;
  logic        pegajoso_C;
  logic        pegajoso_O;
  logic        limpiar;
  logic [7:0]  descartados;

  int n_checks;
  int n_pass;

  alu_cola_resultados dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_S       (in_S),
    .in_Z       (in_Z),
    .in_C       (in_C),
    .in_O       (in_O),
    .in_f       (in_f),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_S      (out_S),
    .out_Z      (out_Z),
    .out_C      (out_C),
    .out_O      (out_O),
    .out_f      (out_f),
    .ocupacion  (ocupacion),
    .pegajoso_Z (pegajoso_Z),
    .pegajoso_C (pegajoso_C),
    .pegajoso_O (pegajoso_O),
    .limpiar    (limpiar),
    .descartados(descartados)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs/outputs are touched 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] s, input logic z, input logic c, input logic o,
                       input logic [3:0] f);
    in_valid = 1'b1;
    in_S = s; in_Z = z; in_C = c; in_O = o; in_f = f;
  endtask

  task automatic push(input logic [31:0] s, input logic z, input logic c, input logic o,
                      input logic [3:0] f);
    drive(s, z, c, o, f);
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] s, input logic z,
                           input logic c, input logic o, input logic [3:0] f);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".entry"}, {25'd0, out_S, out_Z, out_C, out_O, out_f},
          {25'd0, s, z, c, o, f});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b1; in_valid = 1'b0; in_S = '0; in_Z = 0; in_C = 0; in_O = 0; in_f = '0;
    out_ready = 1'b0; limpiar = 1'b0;

    // Reset with in_valid held high.
    #1 rst_n = 1'b0;
    drive(32'h0000_0011, 1'b0, 1'b0, 1'b0, 4'b0100);
    repeat (2) step();
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.ocupacion", 64'(ocupacion), 64'd0);
    check("rst.descartados", 64'(descartados), 64'd0);
    check("rst.sticky", {61'd0, pegajoso_Z, pegajoso_C, pegajoso_O}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    step();
    in_valid = 1'b0;
    check("first.out_valid", 64'(out_valid), 64'd1);
    check("first.ocupacion", 64'(ocupacion), 64'd1);
    pop_check("first", 32'h0000_0011, 1'b0, 1'b0, 1'b0, 4'b0100);
    check("first.empty", 64'(ocupacion), 64'd0);

    // Fill to depth with out_ready low.
    push(32'h0000_0001, 1'b0, 1'b0, 1'b0, 4'b0100);
    push(32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'b1000);
    push(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 4'b0101);
    push(32'h8000_0000, 1'b0, 1'b0, 1'b1, 4'b0110);
    check("full.ocupacion", 64'(ocupacion), 64'd4);
    check("full.in_ready", 64'(in_ready), 64'd0);
    push(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 4'b0100);
    check("full.no_accept", 64'(ocupacion), 64'd4);
    check("full.head_stable", 64'(out_S), 64'h0000_0001);
    check("full.sticky", {61'd0, pegajoso_Z, pegajoso_C, pegajoso_O}, 64'b111);
    pop_check("pop0", 32'h0000_0001, 1'b0, 1'b0, 1'b0, 4'b0100);
    pop_check("pop1", 32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'b1000);
    pop_check("pop2", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 4'b0101);
    pop_check("pop3", 32'h8000_0000, 1'b0, 1'b0, 1'b1, 4'b0110);
    check("drain.out_valid", 64'(out_valid), 64'd0);
    check("drain.ocupacion", 64'(ocupacion), 64'd0);

    // Clear, then a logic op must not touch sticky C/O.
    limpiar = 1'b1; step(); limpiar = 1'b0;
    check("clr.sticky", {61'd0, pegajoso_Z, pegajoso_C, pegajoso_O}, 64'd0);
    push(32'h0000_1234, 1'b0, 1'b1, 1'b1, 4'b1001);
    check("logic.sticky", {61'd0, pegajoso_Z, pegajoso_C, pegajoso_O}, 64'd0);
    pop_check("logic", 32'h0000_1234, 1'b0, 1'b1, 1'b1, 4'b1001);

    // Streaming with consumer always ready: one-cycle latency, pointers wrap.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(32'(100 + i), 1'b0, 1'b0, 1'b0, 4'b0100);
      step();
      check($sformatf("stream%0d.ocupacion", i), 64'(ocupacion), 64'd1);
      check($sformatf("stream%0d.S", i), 64'(out_S), 64'(100 + i));
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("stream.drained", 64'(ocupacion), 64'd0);

    // Invalid ops are counted, not stored.
    for (int i = 0; i < 3; i++) push(32'h5, 1'b1, 1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 2; i++) push(32'h6, 1'b1, 1'b1, 1'b1, 4'b1100);
    check("inval.descartados", 64'(descartados), 64'd5);
    check("inval.ocupacion", 64'(ocupacion), 64'd0);
    check("inval.out_valid", 64'(out_valid), 64'd0);
    check("inval.sticky", {61'd0, pegajoso_Z, pegajoso_C, pegajoso_O}, 64'd0);
    limpiar = 1'b1;
    push(32'h7, 1'b0, 1'b0, 1'b0, 4'b0000);
    limpiar = 1'b0;
    check("clr_inval.descartados", 64'(descartados), 64'd1);

    // Saturation of the discard counter.
    for (int i = 0; i < 260; i++) push(32'h8, 1'b0, 1'b0, 1'b0, 4'b1111);
    check("sat.descartados", 64'(descartados), 64'd255);

    // Clear together with an accepted valid op keeps that op's flags.
    limpiar = 1'b1;
    push(32'h0, 1'b1, 1'b1, 1'b0, 4'b0111);
    limpiar = 1'b0;
    check("clr_valid.sticky", {61'd0, pegajoso_Z, pegajoso_C, pegajoso_O}, 64'b110);
    check("clr_valid.descartados", 64'(descartados), 64'd0);
    pop_check("clr_valid", 32'h0, 1'b1, 1'b1, 1'b0, 4'b0111);

    // Asynchronous reset mid-cycle with entries stored.
    push(32'hA, 1'b0, 1'b0, 1'b0, 4'b0100);
    push(32'hB, 1'b0, 1'b0, 1'b0, 4'b0100);
    push(32'hC, 1'b0, 1'b0, 1'b0, 4'b0100);
    check("arst.pre_ocupacion", 64'(ocupacion), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst.out_valid", 64'(out_valid), 64'd0);
    check("arst.ocupacion", 64'(ocupacion), 64'd0);
    check("arst.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("arst.stale%0d", i), 64'(out_valid), 64'd0);
    end
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
